// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply issue/return controller.
package mul_ctrl_pkg;

  localparam int unsigned MUL_OP_W = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OPND_W   = 34;
  localparam int unsigned PROD_W   = 68;

  // Op encoding; 2'b11 is reserved and executes as MUL_W.
  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL_W   = 2'b00,
    MUL_OP_MULH_W  = 2'b01,
    MUL_OP_MULH_WU = 2'b10,
    MUL_OP_RSVD    = 2'b11
  } mul_op_e;

  // Widen a 32b source to the multiplier's 34b signed operand.
  function automatic logic [OPND_W-1:0] ext_opnd(input logic [DATA_W-1:0] x,
                                                 input logic zext);
    return zext ? {2'b00, x} : {{2{x[DATA_W-1]}}, x};
  endfunction

  // True when the op returns the upper 32b of the 64b product.
  function automatic logic sel_hi(input mul_op_e op);
    return (op == MUL_OP_MULH_W) || (op == MUL_OP_MULH_WU);
  endfunction

endpackage

// File: rtl/mul.sv
// 34x34 signed multiplier producing the full 68b product.
module mul
  import mul_ctrl_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] a_x;
  logic [PROD_W-1:0] b_x;

  // Sign-extend to product width so the modular product equals the signed one.
  assign a_x  = {{(PROD_W-OPND_W){a[OPND_W-1]}}, a};
  assign b_x  = {{(PROD_W-OPND_W){b[OPND_W-1]}}, b};
  assign prod = a_x * b_x;

endmodule

// File: rtl/mul_ctrl.sv
// Two-stage issue/return controller around the 34b multiplier.
// Handshake in cycle c -> operands in S1 during c+1 -> result valid in c+2.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [DATA_W-1:0]   in_src1,
  input  logic [DATA_W-1:0]   in_src2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  // Stage 1: extended operands awaiting the multiplier.
  logic                s1_valid_q, s1_valid_d;
  mul_op_e             s1_op_q,    s1_op_d;
  logic [OPND_W-1:0]   s1_a_q,     s1_a_d;
  logic [OPND_W-1:0]   s1_b_q,     s1_b_d;
  logic [TAG_W-1:0]    s1_tag_q,   s1_tag_d;

  // Stage 2: selected result half awaiting the consumer.
  logic                s2_valid_q,  s2_valid_d;
  logic [DATA_W-1:0]   s2_result_q, s2_result_d;
  logic [TAG_W-1:0]    s2_tag_q,    s2_tag_d;

  logic                s1_ready_c;
  logic                s2_ready_c;
  logic                accept_c;
  mul_op_e             in_op_c;
  logic [PROD_W-1:0]   prod;
  logic [DATA_W-1:0]   result_c;
  logic                unused_prod_hi;

  assign in_op_c = mul_op_e'(in_op);

  // Backpressure chain: each stage frees up if empty or draining downstream.
  assign s2_ready_c = !s2_valid_q || out_ready;
  assign s1_ready_c = !s1_valid_q || s2_ready_c;
  assign in_ready   = s1_ready_c && !flush;
  assign accept_c   = in_valid && in_ready;

  mul u_mul (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .prod (prod)
  );

  // Select the architectural 32b half; bits above 63 carry no information.
  assign result_c       = sel_hi(s1_op_q) ? prod[63:32] : prod[31:0];
  assign unused_prod_hi = ^prod[PROD_W-1:64];

  // Stage 1 next state: flush empties, otherwise load on accept or drain on move.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_ready_c) begin
      s1_valid_d = accept_c;
      if (accept_c) begin
        s1_op_d  = in_op_c;
        s1_a_d   = ext_opnd(in_src1, in_op_c == MUL_OP_MULH_WU);
        s1_b_d   = ext_opnd(in_src2, in_op_c == MUL_OP_MULH_WU);
        s1_tag_d = in_tag;
      end
    end
  end

  // Stage 2 next state: flush empties but keeps the last data visible.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_ready_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = result_c;
        s2_tag_d    = s1_tag_q;
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= MUL_OP_MUL_W;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;
  assign busy       = s1_valid_q || s2_valid_q;

endmodule
